x86_length_decoder: RTL and testbench

- Combinational x86-64 instruction-length decoder between the fetch buffer and decode-offset logic of the core.
- Each cycle it sees the next 15 buffered bytes and reports the byte length of the instruction starting at byte 0.
- The core adds that length to its decode offset in the same cycle.
- A small registered counter tracks instructions decoded.

---
 rtl/x86_length_decoder.sv | 196 +++++++++++++++++++
 tb/tb_x86_length_decoder.sv | 114 +++++++++++
 2 files changed

// File: rtl/x86_length_decoder.sv
// x86-64 instruction-length decoder.
// Looks at a 15-byte window (byte 0 = first instruction byte) and reports, in the
// same cycle, how many bytes the instruction at byte 0 occupies. Malformed or
// overlong encodings report 1 so the core can step past a single byte.
// A registered 64-bit counter tracks how many instructions have been decoded.
module x86_length_decoder #(
    parameter int MAX_LEN = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   can_decode,
    input  logic [63:0]            fetch_rip,
    input  logic [0:MAX_LEN*8-1]   decode_bytes,
    output logic [3:0]             bytes_decoded_this_cycle,
    output logic [63:0]            insn_count
);

    localparam logic [1:0] MAP_1B = 2'd0;
    localparam logic [1:0] MAP_0F = 2'd1;
    localparam logic [1:0] MAP_38 = 2'd2;
    localparam logic [1:0] MAP_3A = 2'd3;

    // The fetch address has no bearing on instruction length.
    logic unused_rip;
    assign unused_rip = ^fetch_rip;

    // Byte at a window position; positions past the window read as zero.
    function automatic logic [7:0] byte_at(input logic [0:MAX_LEN*8-1] w, input logic [4:0] idx);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (idx == 5'(i)) r = w[i*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic is_legacy(input logic [7:0] b);
        return b inside {8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3,
                         8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};
    endfunction

    function automatic logic modrm_1b(input logic [7:0] opc);
        logic r;
        r = (opc < 8'h40) && (opc[2:0] < 3'd4);
        // 62 (EVEX in 64-bit mode) is treated as a legacy opcode that takes ModRM.
        if (opc inside {8'h62, 8'h63, 8'h69, 8'h6B, [8'h80:8'h8F], 8'hC0, 8'hC1,
                        8'hC6, 8'hC7, [8'hD0:8'hD3], [8'hD8:8'hDF],
                        8'hF6, 8'hF7, 8'hFE, 8'hFF}) r = 1'b1;
        return r;
    endfunction

    function automatic logic modrm_0f(input logic [7:0] opc);
        return !(opc inside {[8'h05:8'h09], 8'h0B, [8'h30:8'h37], 8'h77,
                             [8'h80:8'h8F], [8'hA0:8'hA2], 8'hA8, 8'hA9,
                             [8'hC8:8'hCF]});
    endfunction

    function automatic logic [3:0] imm_size(input logic [1:0] map, input logic [7:0] opc,
                                            input logic [2:0] reg_f, input logic op16,
                                            input logic adr32, input logic rex_w);
        logic [3:0] z;
        logic [3:0] r;
        z = (op16 && !rex_w) ? 4'd2 : 4'd4;
        r = 4'd0;
        case (map)
            MAP_1B: begin
                if (opc < 8'h40 && opc[2:0] == 3'd4)      r = 4'd1;
                else if (opc < 8'h40 && opc[2:0] == 3'd5) r = z;
                else if (opc inside {8'h6A, 8'h6B, [8'h70:8'h7F], 8'h80, 8'h82, 8'h83,
                                     8'hA8, [8'hB0:8'hB7], 8'hC0, 8'hC1, 8'hC6, 8'hCD,
                                     8'hD4, 8'hD5, [8'hE0:8'hE7], 8'hEB}) r = 4'd1;
                else if (opc inside {8'h68, 8'h69, 8'h81, 8'hA9, 8'hC7, 8'hE8, 8'hE9}) r = z;
                else if (opc inside {8'hC2, 8'hCA})     r = 4'd2;
                else if (opc == 8'hC8)                   r = 4'd3;
                else if (opc inside {[8'hB8:8'hBF]})     r = rex_w ? 4'd8 : z;
                else if (opc inside {[8'hA0:8'hA3]})     r = adr32 ? 4'd4 : 4'd8;
                else if (opc == 8'hF6 && reg_f < 3'd2)   r = 4'd1;
                else if (opc == 8'hF7 && reg_f < 3'd2)   r = z;
            end
            MAP_0F: begin
                if (opc inside {[8'h70:8'h73], 8'hA4, 8'hAC, 8'hBA, 8'hC2, [8'hC4:8'hC6]})
                    r = 4'd1;
                else if (opc inside {[8'h80:8'h8F]})
                    r = 4'd4;
            end
            MAP_3A:  r = 4'd1;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    logic [2:0] npfx;
    logic       has66, has67, rex_w, pfx_bad, scanning;
    logic [4:0] pos;
    logic [7:0] cur;
    logic [7:0] b0, b1, opc, modrm, sib;
    logic [1:0] map, olen;
    logic [4:0] mi;
    logic       has_modrm;
    logic [2:0] s_len;
    logic [3:0] d_len, i_len;
    logic [5:0] len_raw;

    // Prefix scan: legacy prefixes (max 4) and REX; only a REX directly before the opcode sets W.
    always_comb begin
        npfx     = 3'd0;
        has66    = 1'b0;
        has67    = 1'b0;
        rex_w    = 1'b0;
        pfx_bad  = 1'b0;
        scanning = 1'b1;
        pos      = 5'd0;
        cur      = 8'h00;
        for (int k = 0; k < MAX_LEN; k++) begin
            cur = decode_bytes[k*8 +: 8];
            if (scanning) begin
                if (is_legacy(cur)) begin
                    if (npfx == 3'd4) begin
                        pfx_bad  = 1'b1;
                        scanning = 1'b0;
                    end else begin
                        npfx  = npfx + 3'd1;
                        has66 = has66 | (cur == 8'h66);
                        has67 = has67 | (cur == 8'h67);
                        rex_w = 1'b0;
                        pos   = 5'(k + 1);
                    end
                end else if (cur[7:4] == 4'h4) begin
                    rex_w = cur[3];
                    pos   = 5'(k + 1);
                end else begin
                    scanning = 1'b0;
                end
            end
        end
    end

    // Opcode map, ModRM/SIB/displacement/immediate sizing and final length.
    always_comb begin
        b0 = byte_at(decode_bytes, pos);
        b1 = byte_at(decode_bytes, pos + 5'd1);
        if (b0 != 8'h0F) begin
            map  = MAP_1B;
            olen = 2'd1;
            opc  = b0;
        end else if (b1 == 8'h38 || b1 == 8'h3A) begin
            map  = (b1 == 8'h38) ? MAP_38 : MAP_3A;
            olen = 2'd3;
            opc  = byte_at(decode_bytes, pos + 5'd2);
        end else begin
            map  = MAP_0F;
            olen = 2'd2;
            opc  = b1;
        end

        mi    = pos + 5'(olen);
        modrm = byte_at(decode_bytes, mi);
        sib   = byte_at(decode_bytes, mi + 5'd1);

        case (map)
            MAP_1B:  has_modrm = modrm_1b(opc);
            MAP_0F:  has_modrm = modrm_0f(opc);
            default: has_modrm = 1'b1;
        endcase

        s_len = 3'd0;
        d_len = 4'd0;
        if (has_modrm && modrm[7:6] != 2'b11) begin
            if (modrm[2:0] == 3'b100) s_len = 3'd1;
            if (modrm[7:6] == 2'b01) d_len = 4'd1;
            else if (modrm[7:6] == 2'b10) d_len = 4'd4;
            else if (modrm[2:0] == 3'b101) d_len = 4'd4;
            else if (modrm[2:0] == 3'b100 && sib[2:0] == 3'b101) d_len = 4'd4;
        end

        i_len = imm_size(map, opc, modrm[5:3], has66, has67, rex_w);

        len_raw = 6'(pos) + 6'(olen) + 6'(has_modrm) + 6'(s_len) + 6'(d_len) + 6'(i_len);

        if (!can_decode)
            bytes_decoded_this_cycle = 4'd0;
        else if (pfx_bad || len_raw > 6'(MAX_LEN))
            bytes_decoded_this_cycle = 4'd1;
        else
            bytes_decoded_this_cycle = len_raw[3:0];
    end

    // Count every cycle in which an instruction (of any non-zero length) is consumed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            insn_count <= 64'd0;
        else if (bytes_decoded_this_cycle != 4'd0)
            insn_count <= insn_count + 64'd1;
    end

endmodule

// File: tb/tb_x86_length_decoder.sv
// Directed bench for x86_length_decoder: hand-computed lengths and instruction counts.
module tb_x86_length_decoder;

    logic          clk = 1'b0;
    logic          reset;
    logic          can_decode;
    logic [63:0]   fetch_rip;
    logic [0:119]  decode_bytes;
    logic [3:0]    bytes_decoded_this_cycle;
    logic [63:0]   insn_count;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_count;

    x86_length_decoder #(.MAX_LEN(15)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .can_decode               (can_decode),
        .fetch_rip                (fetch_rip),
        .decode_bytes             (decode_bytes),
        .bytes_decoded_this_cycle (bytes_decoded_this_cycle),
        .insn_count               (insn_count)
    );

    always #5 clk = ~clk;

    task automatic chk_len(input string tag, input logic [3:0] exp);
        tests++;
        assert (bytes_decoded_this_cycle === exp) else begin
            fails++;
            $error("FAIL %s: length got %0d expected %0d", tag, bytes_decoded_this_cycle, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [63:0] exp);
        tests++;
        assert (insn_count === exp) else begin
            fails++;
            $error("FAIL %s: insn_count got %0d expected %0d", tag, insn_count, exp);
        end
    endtask

    // Window is written most-significant byte first: the first byte of the literal is byte 0.
    task automatic vec(input string tag, input logic [0:119] w, input logic [3:0] exp);
        @(negedge clk);
        decode_bytes = w;
        can_decode   = 1'b1;
        fetch_rip    = {$urandom, $urandom};
        #1 chk_len(tag, exp);
        @(posedge clk);
        exp_count = exp_count + 64'd1;
        #1 chk_cnt({tag, "_cnt"}, exp_count);
    endtask

    initial begin
        reset        = 1'b0;
        can_decode   = 1'b0;
        fetch_rip    = 64'h0;
        decode_bytes = '0;
        exp_count    = 64'd0;
        #1;
        chk_cnt("reset_cnt", 64'd0);
        chk_len("reset_len", 4'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // can_decode low: no length, no count
        @(negedge clk);
        can_decode   = 1'b0;
        decode_bytes = {24'h4889E5, 96'h0};
        #1 chk_len("no_decode", 4'd0);
        @(posedge clk);
        #1 chk_cnt("no_decode_cnt", exp_count);

        vec("mov_rbp_rsp",  {24'h4889E5, 96'h0}, 4'd3);
        vec("mov_eax_imm",  {40'hB801000000, 80'h0}, 4'd5);
        vec("movabs",       {80'h48B81122334455667788, 40'h0}, 4'd10);
        vec("mov_ax_imm",   {32'h66B83412, 88'h0}, 4'd4);
        vec("sib_nodisp",   {24'h8B0424, 96'h0}, 4'd3);
        vec("riprel",       {48'h8B0578563412, 72'h0}, 4'd6);
        vec("sib_disp8",    {32'h8B442408, 88'h0}, 4'd4);
        vec("sib_base101",  {56'h8B042578563412, 64'h0}, 4'd7);
        vec("add_d32_i32",  {88'h81842478563412EFBEADDE, 32'h0}, 4'd11);
        vec("jcc_rel32",    {48'h0F8478563412, 72'h0}, 4'd6);
        vec("imul_0f",      {24'h0FAFC1, 96'h0}, 4'd3);
        vec("palignr_3a",   {40'h0F3A0FC108, 80'h0}, 4'd5);
        vec("ret",          {8'hC3, 112'h0}, 4'd1);
        vec("test_r8_imm",  {24'hF6C001, 96'h0}, 4'd3);
        vec("test_r32_imm", {48'hF7C078563412, 72'h0}, 4'd6);
        vec("five_prefix",  {48'h6667F02E6690, 72'h0}, 4'd1);
        vec("all_zero",     120'h0, 4'd2);
        vec("overlong",     120'h2E2E2E2E48818424785634_12EFBEAD, 4'd1);
        vec("moffs_a32",    {48'h67A178563412, 72'h0}, 4'd6);
        vec("rex_then_66",  {40'h4866B83412, 80'h0}, 4'd5);
        vec("all_rex",      {15{8'h48}}, 4'd1);
        vec("not_grp3",     {24'hF6D000, 96'h0}, 4'd2);

        // Asynchronous reset mid-run, away from any clock edge
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_cnt("async_reset", 64'd0);
        @(negedge clk);
        reset        = 1'b1;
        can_decode   = 1'b1;
        decode_bytes = {8'hC3, 112'h0};
        repeat (3) @(posedge clk);
        #1 chk_cnt("count_after_reset", 64'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
